// File: rtl/layered_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : layered_sprite_compositor
// Description : Two-stage pixel compositor. Layers solid boxes, centred
//               sprites with colour-key transparency and hit-flash, and a
//               wall/floor tile background into registered 4:4:4 RGB.
//               Sprite, maze and texture ROMs are addressed in stage 1 and
//               their data is consumed in stage 2.
// Revision    : 1.0 - initial release
// ============================================================================
module layered_sprite_compositor #(
    parameter int          NUM_SPR      = 2,
    parameter int          SPR_SIZE     = 16,
    parameter int          NUM_BOX      = 6,
    parameter int          BOX_SIZE     = 4,
    parameter int          TILE_W       = 32,
    parameter int          TILE_H       = 24,
    parameter int          MAZE_W       = 20,
    parameter int          MAZE_H       = 20,
    parameter logic [11:0] KEY_RGB      = 12'hFFF,
    parameter int          FLASH_FRAMES = 8,
    parameter logic [11:0] FLASH_RGB    = 12'hF00,
    localparam int         SA           = $clog2(SPR_SIZE)
) (
    input  logic                    Clk,
    input  logic                    Reset_n,
    input  logic                    pix_valid,
    input  logic                    frame_start,
    input  logic [9:0]              DrawX,
    input  logic [9:0]              DrawY,
    input  logic [10*NUM_SPR-1:0]   spr_x,
    input  logic [10*NUM_SPR-1:0]   spr_y,
    input  logic [NUM_SPR-1:0]      spr_hit,
    output logic [2*SA*NUM_SPR-1:0] spr_addr,
    input  logic [12*NUM_SPR-1:0]   spr_rgb,
    input  logic [10*NUM_BOX-1:0]   box_x,
    input  logic [10*NUM_BOX-1:0]   box_y,
    input  logic [NUM_BOX-1:0]      box_en,
    input  logic [12*NUM_BOX-1:0]   box_rgb,
    output logic [4:0]              tile_x,
    output logic [4:0]              tile_y,
    input  logic                    wall_bit,
    input  logic [11:0]             wall_rgb,
    input  logic [11:0]             floor_rgb,
    output logic [3:0]              Red,
    output logic [3:0]              Green,
    output logic [3:0]              Blue,
    output logic                    out_valid
);

    localparam int         c_FCW        = $clog2(FLASH_FRAMES + 1);
    localparam logic [c_FCW-1:0] c_FLASH_LOAD = c_FCW'(FLASH_FRAMES);
    localparam logic [9:0] c_HALF       = 10'(SPR_SIZE / 2);
    localparam logic [9:0] c_SPR_SIZE   = 10'(SPR_SIZE);
    localparam logic [10:0] c_BOX_SIZE  = 11'(BOX_SIZE);

    // ------------------------------------------------------------------
    // Stage-1 combinational terms
    // ------------------------------------------------------------------
    logic [NUM_SPR-1:0]      w_inbox;
    logic [2*SA*NUM_SPR-1:0] w_addr;
    logic [NUM_SPR-1:0]      w_flash_on;
    logic [NUM_BOX-1:0]      w_box_in;
    logic                    w_box_hit;
    logic [11:0]             w_box_col;
    logic [9:0]              w_tile_x_full;
    logic [9:0]              w_tile_y_full;
    logic                    w_tile_ok;

    // Stage-1 registers
    logic                    r_pv;
    logic [NUM_SPR-1:0]      r_inbox;
    logic [NUM_SPR-1:0]      r_flash_on;
    logic                    r_box_hit;
    logic [11:0]             r_box_rgb;
    logic                    r_tile_ok;

    // Stage-2 combinational terms
    logic                    w_spr_hit;
    logic [11:0]             w_spr_col;
    logic [11:0]             w_pix_rgb;

    // Sprite window: the relative offset wraps in 10 bits, so a sprite near
    // the right/bottom edge also shows at the opposite edge.
    for (genvar i = 0; i < NUM_SPR; i++) begin : g_spr
        logic [9:0] w_rel_x;
        logic [9:0] w_rel_y;
        assign w_rel_x = DrawX - spr_x[10*i +: 10] + c_HALF;
        assign w_rel_y = DrawY - spr_y[10*i +: 10] + c_HALF;
        assign w_inbox[i] = (w_rel_x < c_SPR_SIZE) && (w_rel_y < c_SPR_SIZE);
        assign w_addr[2*SA*i +: 2*SA] = {w_rel_y[SA-1:0], w_rel_x[SA-1:0]};
    end

    // Box window: 11-bit compares so a box near X=1023 never wraps to X=0.
    for (genvar j = 0; j < NUM_BOX; j++) begin : g_box
        logic [10:0] w_lo_x;
        logic [10:0] w_lo_y;
        logic [10:0] w_hi_x;
        logic [10:0] w_hi_y;
        assign w_lo_x = {1'b0, box_x[10*j +: 10]};
        assign w_lo_y = {1'b0, box_y[10*j +: 10]};
        assign w_hi_x = w_lo_x + c_BOX_SIZE;
        assign w_hi_y = w_lo_y + c_BOX_SIZE;
        assign w_box_in[j] = box_en[j]
                           && ({1'b0, DrawX} >= w_lo_x) && ({1'b0, DrawX} < w_hi_x)
                           && ({1'b0, DrawY} >= w_lo_y) && ({1'b0, DrawY} < w_hi_y);
    end

    // Hit-flash counter per sprite: a hit reloads, frame_start counts down
    // to zero; blink-on frames are the odd counts.
    for (genvar i = 0; i < NUM_SPR; i++) begin : g_flash
        logic [c_FCW-1:0] r_cnt;

        // Load on hit (wins over frame_start), otherwise saturating decrement
        always_ff @(posedge Clk or negedge Reset_n) begin
            if (!Reset_n) begin
                r_cnt <= '0;
            end else if (spr_hit[i]) begin
                r_cnt <= c_FLASH_LOAD;
            end else if (frame_start && (r_cnt != '0)) begin
                r_cnt <= r_cnt - 1'b1;
            end
        end

        assign w_flash_on[i] = (r_cnt != '0) && r_cnt[0];
    end

    // Lowest-index hit box wins: scan from the top down so index 0 lands last
    always_comb begin
        w_box_hit = 1'b0;
        w_box_col = '0;
        for (int j = NUM_BOX - 1; j >= 0; j--) begin
            if (w_box_in[j]) begin
                w_box_hit = 1'b1;
                w_box_col = box_rgb[12*j +: 12];
            end
        end
    end

    // Tile coordinates are range-checked at full width before truncation
    assign w_tile_x_full = DrawX / 10'(TILE_W);
    assign w_tile_y_full = DrawY / 10'(TILE_H);
    assign w_tile_ok     = (w_tile_x_full < 10'(MAZE_W)) && (w_tile_y_full < 10'(MAZE_H));

    // Stage 1: register ROM addresses and per-pixel geometry results
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            r_pv       <= 1'b0;
            spr_addr   <= '0;
            tile_x     <= '0;
            tile_y     <= '0;
            r_tile_ok  <= 1'b0;
            r_inbox    <= '0;
            r_flash_on <= '0;
            r_box_hit  <= 1'b0;
            r_box_rgb  <= '0;
        end else begin
            r_pv       <= pix_valid;
            spr_addr   <= w_addr;
            tile_x     <= w_tile_x_full[4:0];
            tile_y     <= w_tile_y_full[4:0];
            r_tile_ok  <= w_tile_ok;
            r_inbox    <= w_inbox;
            r_flash_on <= w_flash_on;
            r_box_hit  <= w_box_hit;
            r_box_rgb  <= w_box_col;
        end
    end

    // Lowest-index opaque in-box sprite wins; key-coloured pixels fall through
    always_comb begin
        w_spr_hit = 1'b0;
        w_spr_col = '0;
        for (int i = NUM_SPR - 1; i >= 0; i--) begin
            if (r_inbox[i] && (spr_rgb[12*i +: 12] != KEY_RGB)) begin
                w_spr_hit = 1'b1;
                w_spr_col = r_flash_on[i] ? FLASH_RGB : spr_rgb[12*i +: 12];
            end
        end
    end

    // Layer priority: blanking, box, sprite, wall, floor
    always_comb begin
        w_pix_rgb = floor_rgb;
        if (!r_pv) begin
            w_pix_rgb = '0;
        end else if (r_box_hit) begin
            w_pix_rgb = r_box_rgb;
        end else if (w_spr_hit) begin
            w_pix_rgb = w_spr_col;
        end else if (r_tile_ok && wall_bit) begin
            w_pix_rgb = wall_rgb;
        end
    end

    // Stage 2: register the resolved colour
    always_ff @(posedge Clk or negedge Reset_n) begin
        if (!Reset_n) begin
            Red       <= '0;
            Green     <= '0;
            Blue      <= '0;
            out_valid <= 1'b0;
        end else begin
            Red       <= w_pix_rgb[11:8];
            Green     <= w_pix_rgb[7:4];
            Blue      <= w_pix_rgb[3:0];
            out_valid <= r_pv;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_layered_sprite_compositor.sv
`default_nettype none
// ============================================================================
// Module      : tb_layered_sprite_compositor
// Description : Scoreboard bench for layered_sprite_compositor. A reference
//               model predicts ROM addresses and final colours per pixel;
//               a monitor compares them as the DUT presents them.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_layered_sprite_compositor;

    localparam int c_NS = 2;
    localparam int c_NB = 6;

    logic          Clk = 1'b0;
    logic          Reset_n = 1'b0;
    logic          pix_valid = 1'b0;
    logic          frame_start = 1'b0;
    logic [9:0]    DrawX = '0;
    logic [9:0]    DrawY = '0;
    logic [19:0]   spr_x = '0;
    logic [19:0]   spr_y = '0;
    logic [1:0]    spr_hit = '0;
    logic [15:0]   spr_addr;
    logic [23:0]   spr_rgb = '0;
    logic [59:0]   box_x = '0;
    logic [59:0]   box_y = '0;
    logic [5:0]    box_en = '0;
    logic [71:0]   box_rgb = '0;
    logic [4:0]    tile_x;
    logic [4:0]    tile_y;
    logic          wall_bit = 1'b0;
    logic [11:0]   wall_rgb = '0;
    logic [11:0]   floor_rgb = '0;
    logic [3:0]    Red;
    logic [3:0]    Green;
    logic [3:0]    Blue;
    logic          out_valid;

    layered_sprite_compositor dut (
        .Clk(Clk), .Reset_n(Reset_n), .pix_valid(pix_valid), .frame_start(frame_start),
        .DrawX(DrawX), .DrawY(DrawY), .spr_x(spr_x), .spr_y(spr_y), .spr_hit(spr_hit),
        .spr_addr(spr_addr), .spr_rgb(spr_rgb), .box_x(box_x), .box_y(box_y),
        .box_en(box_en), .box_rgb(box_rgb), .tile_x(tile_x), .tile_y(tile_y),
        .wall_bit(wall_bit), .wall_rgb(wall_rgb), .floor_rgb(floor_rgb),
        .Red(Red), .Green(Green), .Blue(Blue), .out_valid(out_valid)
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic [15:0] addr;
        logic [4:0]  tx;
        logic [4:0]  ty;
    } addr_exp_t;

    typedef struct packed {
        logic        pv;
        logic        box_hit;
        logic [11:0] box_col;
        logic [1:0]  inbox;
        logic [1:0]  flash;
        logic        tile_ok;
    } pend_t;

    addr_exp_t   q_addr[$];
    logic [11:0] q_out[$];
    pend_t       pend;
    logic        pend_valid = 1'b0;
    int          flash_cnt[c_NS];
    int          n_chk = 0;
    int          n_pass = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    endtask

    // Model one clock: deliver ROM/maze data for the previous pixel, then
    // present the new pixel and record what the DUT must produce for it.
    task automatic tick(input logic [9:0] x, input logic [9:0] y, input logic pv,
                        input logic [23:0] ret_spr, input logic ret_wb,
                        input logic [11:0] ret_wall, input logic [11:0] ret_floor);
        addr_exp_t   a;
        logic [11:0] col;
        logic        found;
        int          rx, ry, tx, ty, bx, by;
        spr_rgb   = ret_spr;
        wall_bit  = ret_wb;
        wall_rgb  = ret_wall;
        floor_rgb = ret_floor;
        if (pend_valid && pend.pv) begin
            found = 1'b0;
            col   = ret_floor;
            if (pend.box_hit) begin
                col = pend.box_col;
                found = 1'b1;
            end
            for (int i = 0; i < c_NS; i++) begin
                if (!found && pend.inbox[i] && ret_spr[12*i +: 12] != 12'hFFF) begin
                    col = pend.flash[i] ? 12'hF00 : ret_spr[12*i +: 12];
                    found = 1'b1;
                end
            end
            if (!found && ret_wb && pend.tile_ok) col = ret_wall;
            q_out.push_back(col);
        end
        DrawX = x;
        DrawY = y;
        pix_valid = pv;
        a.addr = '0;
        pend.pv = pv;
        for (int i = 0; i < c_NS; i++) begin
            rx = ((int'(x) - int'(spr_x[10*i +: 10]) + 8) % 1024 + 1024) % 1024;
            ry = ((int'(y) - int'(spr_y[10*i +: 10]) + 8) % 1024 + 1024) % 1024;
            pend.inbox[i] = (rx < 16) && (ry < 16);
            a.addr[8*i +: 8] = 8'((ry % 16) * 16 + (rx % 16));
            pend.flash[i] = (flash_cnt[i] != 0) && (flash_cnt[i] % 2 == 1);
            if (spr_hit[i]) flash_cnt[i] = 8;
            else if (frame_start && flash_cnt[i] > 0) flash_cnt[i]--;
        end
        tx = int'(x) / 32;
        ty = int'(y) / 24;
        a.tx = 5'(tx % 32);
        a.ty = 5'(ty % 32);
        pend.tile_ok = (tx < 20) && (ty < 20);
        pend.box_hit = 1'b0;
        pend.box_col = '0;
        for (int j = 0; j < c_NB; j++) begin
            bx = int'(box_x[10*j +: 10]);
            by = int'(box_y[10*j +: 10]);
            if (!pend.box_hit && box_en[j] && int'(x) >= bx && int'(x) < bx + 4
                && int'(y) >= by && int'(y) < by + 4) begin
                pend.box_hit = 1'b1;
                pend.box_col = box_rgb[12*j +: 12];
            end
        end
        pend_valid = 1'b1;
        q_addr.push_back(a);
        @(negedge Clk);
        spr_hit = '0;
        frame_start = 1'b0;
    endtask

    task automatic do_reset();
        Reset_n = 1'b0;
        #1;
        chk("rst_rgb", {Red, Green, Blue}, 12'h000);
        chk("rst_valid", out_valid, 1'b0);
        chk("rst_addr", spr_addr, 16'h0000);
        chk("rst_tile", {tile_x, tile_y}, 10'h000);
        q_addr.delete();
        q_out.delete();
        pend_valid = 1'b0;
        for (int i = 0; i < c_NS; i++) flash_cnt[i] = 0;
        pix_valid = 1'b0;
        spr_hit = '0;
        frame_start = 1'b0;
        @(negedge Clk);
        @(negedge Clk);
        Reset_n = 1'b1;
    endtask

    // Monitor: sample just after each active edge and compare with the queues
    initial begin
        addr_exp_t   a;
        logic [11:0] e;
        forever begin
            @(posedge Clk);
            #1;
            if (q_addr.size() > 0) begin
                a = q_addr.pop_front();
                chk("spr_addr", spr_addr, a.addr);
                chk("tile_x", tile_x, a.tx);
                chk("tile_y", tile_y, a.ty);
            end
            if (out_valid === 1'b1) begin
                if (q_out.size() == 0) chk("spurious_valid", out_valid, 1'b0);
                else begin
                    e = q_out.pop_front();
                    chk("rgb", {Red, Green, Blue}, e);
                end
            end else begin
                chk("idle_rgb", {Red, Green, Blue}, 12'h000);
            end
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog expired actual=timeout required=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [9:0]  x, y;
        logic [23:0] rs;
        int          d;
        for (int i = 0; i < c_NS; i++) flash_cnt[i] = 0;
        @(negedge Clk);
        do_reset();

        // First valid output appears on the second edge after release
        spr_x = {10'd500, 10'd100};
        spr_y = {10'd500, 10'd100};
        tick(10'd0, 10'd0, 1'b1, 24'h0, 1'b0, 12'h0, 12'h111);
        chk("rst_edge1_valid", out_valid, 1'b0);
        tick(10'd92, 10'd92, 1'b1, 24'h0, 1'b0, 12'h0, 12'h222);
        chk("rst_edge2_valid", out_valid, 1'b1);

        // Latency / sprite address / out-of-box
        tick(10'd108, 10'd92, 1'b1, {12'h000, 12'h123}, 1'b0, 12'h0BB, 12'h333);
        tick(10'd0, 10'd0, 1'b1, {12'h000, 12'h321}, 1'b0, 12'h0BB, 12'h456);

        // Transparency: spr0 keyed falls to spr1, both keyed falls to wall
        spr_x = {10'd204, 10'd200};
        spr_y = {10'd204, 10'd200};
        tick(10'd205, 10'd205, 1'b1, 24'h0, 1'b0, 12'h0, 12'h456);
        tick(10'd205, 10'd205, 1'b1, {12'h0A0, 12'hFFF}, 1'b1, 12'h0BB, 12'h456);
        tick(10'd0, 10'd0, 1'b0, {12'hFFF, 12'hFFF}, 1'b1, 12'h0BB, 12'h456);

        // Box priority, disabled box, out-of-maze tile
        spr_x = {10'd500, 10'd52};
        spr_y = {10'd500, 10'd52};
        box_x[9:0] = 10'd50;  box_y[9:0] = 10'd50;  box_rgb[11:0] = 12'hFEE;
        box_en = 6'b000001;
        tick(10'd51, 10'd51, 1'b1, 24'h0, 1'b0, 12'h0, 12'h456);
        box_en = 6'b000100;
        box_x[29:20] = 10'd50; box_y[29:20] = 10'd50; box_rgb[35:24] = 12'h3C5;
        tick(10'd51, 10'd51, 1'b1, {12'h0, 12'h777}, 1'b0, 12'h0, 12'h456);
        box_en = '0;
        tick(10'd640, 10'd10, 1'b1, {12'h0, 12'h777}, 1'b0, 12'h0, 12'h456);
        tick(10'd0, 10'd0, 1'b0, 24'h0, 1'b1, 12'h0BB, 12'h5E5);

        // Flash: hit, hit with frame_start, then count down through zero
        spr_x = {10'd500, 10'd300};
        spr_y = {10'd500, 10'd300};
        spr_hit = 2'b01;
        tick(10'd300, 10'd300, 1'b1, 24'h0, 1'b0, 12'h0, 12'h456);
        spr_hit = 2'b01;
        frame_start = 1'b1;
        tick(10'd300, 10'd300, 1'b1, {12'h0, 12'h5A5}, 1'b0, 12'h0, 12'h456);
        for (int k = 0; k < 10; k++) begin
            frame_start = 1'b1;
            tick(10'd300, 10'd300, 1'b1, {12'h0, 12'h5A5}, 1'b0, 12'h0, 12'h456);
        end

        // Wrap: sprite straddles X=0; box at the right edge does not wrap
        spr_x = {10'd500, 10'd2};
        spr_y = {10'd500, 10'd100};
        box_x[9:0] = 10'd1022; box_y[9:0] = 10'd0; box_rgb[11:0] = 12'hABC;
        box_en = 6'b000001;
        tick(10'd1020, 10'd100, 1'b1, {12'h0, 12'h5A5}, 1'b0, 12'h0, 12'h456);
        tick(10'd1, 10'd1, 1'b1, {12'h0, 12'h246}, 1'b0, 12'h0, 12'h456);
        tick(10'd1023, 10'd1, 1'b1, {12'h0, 12'h246}, 1'b0, 12'h0, 12'h468);
        tick(10'd0, 10'd0, 1'b0, {12'h0, 12'h246}, 1'b0, 12'h0, 12'h468);

        // Randomized traffic with objects clustered around the scan position
        for (int n = 0; n < 3000; n++) begin
            x = 10'($urandom_range(0, 1023));
            y = 10'($urandom_range(0, 1023));
            for (int i = 0; i < c_NS; i++) begin
                d = int'($urandom_range(0, 24));
                spr_x[10*i +: 10] = 10'(int'(x) + d - 12);
                d = int'($urandom_range(0, 24));
                spr_y[10*i +: 10] = 10'(int'(y) + d - 12);
                rs[12*i +: 12] = ($urandom_range(0, 9) < 3) ? 12'hFFF : 12'($urandom);
                spr_hit[i] = ($urandom_range(0, 40) == 0);
            end
            for (int j = 0; j < c_NB; j++) begin
                box_en[j] = ($urandom_range(0, 3) == 0);
                d = int'($urandom_range(0, 5));
                box_x[10*j +: 10] = 10'(int'(x) - d);
                d = int'($urandom_range(0, 5));
                box_y[10*j +: 10] = 10'(int'(y) - d);
                box_rgb[12*j +: 12] = 12'($urandom);
            end
            frame_start = ($urandom_range(0, 15) == 0);
            if (n == 1500) do_reset();
            tick(x, y, ($urandom_range(0, 99) < 85), rs, 1'($urandom),
                 12'($urandom), 12'($urandom));
        end

        // Drain the pipeline
        for (int k = 0; k < 4; k++) tick(10'd0, 10'd0, 1'b0, 24'h0, 1'b0, 12'h0, 12'h0);
        chk("drain_out_queue", q_out.size(), 0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
